// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: access-size
// encodings, arbiter state type and byte-enable generation.
package dm_arb_pkg;

  // Access size encodings carried on size0/size1.
  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Byte enables for an access of the given size at the given byte offset.
  // Misalignment is not masked here; the caller gates BE with its error flag.
  function automatic logic [3:0] be_gen(input logic [1:0] size,
                                        input logic [1:0] alo);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << alo;
      SZ_H:    be = alo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: byte enables, alignment/size error and
// lane extraction with sign/zero extension of the DM read word.
module dm_lane_unit
  import dm_arb_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_alo,
  input  logic        i_sext,
  input  logic [31:0] i_rd,
  output logic [3:0]  o_be,
  output logic        o_err,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign o_be = be_gen(i_size, i_alo);

  // Illegal size, odd halfword or non-word-aligned word access.
  always_comb begin
    o_err = 1'b0;
    case (i_size)
      SZ_H:    o_err = i_alo[0];
      SZ_W:    o_err = (i_alo != 2'b00);
      SZ_BAD:  o_err = 1'b1;
      default: o_err = 1'b0;
    endcase
  end

  // Pick the addressed lane out of the read word.
  always_comb begin
    w_byte = i_rd[7:0];
    case (i_alo)
      2'd0:    w_byte = i_rd[7:0];
      2'd1:    w_byte = i_rd[15:8];
      2'd2:    w_byte = i_rd[23:16];
      default: w_byte = i_rd[31:24];
    endcase
    w_half = i_alo[1] ? i_rd[31:16] : i_rd[15:0];
  end

  // Extend the selected lane to 32 bits.
  always_comb begin
    o_ldata = 32'h0;
    case (i_size)
      SZ_B:    o_ldata = {{24{i_sext & w_byte[7]}}, w_byte};
      SZ_H:    o_ldata = {{16{i_sext & w_half[15]}}, w_half};
      SZ_W:    o_ldata = i_rd;
      default: o_ldata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between the
// CPU MEM stage (requester 0) and the debug/loader port (requester 1).
// Each access takes one BUSY cycle; the result returns with a one-cycle ack.
// Optional build macro DM_ARB_STATS_EN adds saturating per-requester
// stall counters (stall0/stall1, CNT_W bits).
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW = 13
`ifdef DM_ARB_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [1:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  input  logic          we0,
  input  logic          we1,
  input  logic [1:0]    size0,
  input  logic [1:0]    size1,
  input  logic          sext0,
  input  logic          sext1,
  output logic [1:0]    ack,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [AW-3:0] dm_A,
  output logic [31:0]   dm_WD,
  output logic          dm_We,
  output logic [3:0]    dm_BE,
  input  logic [31:0]   dm_RD
`ifdef DM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stall0,
  output logic [CNT_W-1:0] stall1
`endif
);

  arb_state_t    r_state;
  logic [1:0]    r_ack;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic          r_last_gnt;
  logic          r_win;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_sext;

  logic [1:0]    w_elig;
  logic          w_gnt_vld;
  logic          w_gnt_idx;
  logic          w_busy;
  logic [3:0]    w_be;
  logic          w_err;
  logic [31:0]   w_ldata;

  // A requester being acked this cycle still holds req; exclude it so the
  // same access is not issued twice.
  assign w_elig    = req & ~r_ack;
  assign w_gnt_vld = (r_state == IDLE) && (w_elig != 2'b00);
  assign w_gnt_idx = (w_elig == 2'b11) ? ~r_last_gnt : w_elig[1];
  assign w_busy    = (r_state == BUSY);

  dm_lane_unit u_lane (
    .i_size  (r_size),
    .i_alo   (r_addr[1:0]),
    .i_sext  (r_sext),
    .i_rd    (dm_RD),
    .o_be    (w_be),
    .o_err   (w_err),
    .o_ldata (w_ldata)
  );

  // DM address and data follow the latched request; strobes only in BUSY.
  assign dm_A  = r_addr[AW-1:2];
  assign dm_WD = r_wdata;
  assign dm_We = w_busy & r_we & ~w_err;
  assign dm_BE = (w_busy && !w_err) ? w_be : 4'b0000;

  assign ack   = r_ack;
  assign err   = r_err;
  assign rdata = r_rdata;

  // Arbitration FSM: latch the winner in IDLE, complete it in one BUSY cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_ack      <= 2'b00;
      r_err      <= 1'b0;
      r_rdata    <= 32'h0;
      r_last_gnt <= 1'b1;
      r_win      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_we       <= 1'b0;
      r_size     <= SZ_B;
      r_sext     <= 1'b0;
    end else begin
      r_ack <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_addr     <= w_gnt_idx ? addr1  : addr0;
            r_wdata    <= w_gnt_idx ? wdata1 : wdata0;
            r_we       <= w_gnt_idx ? we1    : we0;
            r_size     <= w_gnt_idx ? size1  : size0;
            r_sext     <= w_gnt_idx ? sext1  : sext0;
            r_win      <= w_gnt_idx;
            r_last_gnt <= w_gnt_idx;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_ack[r_win] <= 1'b1;
          r_err        <= w_err;
          r_rdata      <= (!r_we && !w_err) ? w_ldata : 32'h0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DM_ARB_STATS_EN
  logic w_wait0;
  logic w_wait1;

  // A cycle counts as stalled when the request is pending and not granted.
  assign w_wait0 = req[0] & ~r_ack[0] & ~(w_gnt_vld & ~w_gnt_idx);
  assign w_wait1 = req[1] & ~r_ack[1] & ~(w_gnt_vld &  w_gnt_idx);

  // Saturating stall counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall0 <= '0;
      stall1 <= '0;
    end else begin
      if (w_wait0 && (stall0 != {CNT_W{1'b1}})) stall0 <= stall0 + 1'b1;
      if (w_wait1 && (stall1 != {CNT_W{1'b1}})) stall1 <= stall1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Testbench for dm_port_arbiter: a word-wide DM model on the memory side,
// a byte-addressed reference model feeding per-requester expectation
// queues, and a monitor that checks every ack against those queues.
module tb_dm_port_arbiter;

  localparam int AW = 13;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          rq0, rq1;
  wire  [1:0]    req = {rq1, rq0};
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          we0, we1;
  logic [1:0]    size0, size1;
  logic          sext0, sext1;
  logic [1:0]    ack;
  logic          err;
  logic [31:0]   rdata;
  logic [10:0]   dm_A;
  logic [31:0]   dm_WD;
  logic          dm_We;
  logic [3:0]    dm_BE;
  logic [31:0]   dm_RD;
`ifdef DM_ARB_STATS_EN
  logic [15:0]   stall0, stall1;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  dm_port_arbiter dut (
    .Clk(Clk), .Reset(Reset), .req(req),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1), .size0(size0), .size1(size1),
    .sext0(sext0), .sext1(sext1),
    .ack(ack), .err(err), .rdata(rdata),
    .dm_A(dm_A), .dm_WD(dm_WD), .dm_We(dm_We), .dm_BE(dm_BE), .dm_RD(dm_RD)
`ifdef DM_ARB_STATS_EN
    , .stall0(stall0), .stall1(stall1)
`endif
  );

  // DM macro model: combinational read, lane-steering byte-enable write.
  logic [31:0] dm_mem [0:2047];
  initial for (int k = 0; k < 2048; k++) dm_mem[k] = 32'h0;
  assign dm_RD = dm_mem[dm_A];

  function automatic logic [31:0] dm_merge(input logic [31:0] old,
                                           input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] w;
    int lo;
    w  = old;
    lo = 4;
    for (int k = 3; k >= 0; k--) if (be[k]) lo = k;
    for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wd[8*(k-lo) +: 8];
    return w;
  endfunction

  always @(posedge Clk) if (dm_We) dm_mem[dm_A] <= dm_merge(dm_mem[dm_A], dm_WD, dm_BE);

  // Reference model: flat byte memory, little-endian, executed at issue time.
  logic [7:0]  ref_mem [0:8191];
  initial for (int k = 0; k < 8192; k++) ref_mem[k] = 8'h0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  function automatic void model(input int i, input logic [12:0] a,
                                input logic [31:0] wd, input logic we,
                                input logic [1:0] sz, input logic sx);
    logic e;
    logic [31:0] v;
    int n;
    e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    v = 32'h0;
    if (!e) begin
      n = 1 << sz;
      if (we) begin
        for (int b = 0; b < n; b++) ref_mem[int'(a) + b] = wd[8*b +: 8];
      end else begin
        for (int b = 0; b < n; b++) v[8*b +: 8] = ref_mem[int'(a) + b];
        if (sx && v[8*n-1]) for (int b = n; b < 4; b++) v[8*b +: 8] = 8'hFF;
      end
    end
    if (i == 0) q0.push_back({e, v});
    else        q1.push_back({e, v});
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every ack pops the requester's oldest expectation.
  task automatic mon(input int i);
    logic [32:0] e;
    int sz;
    sz = (i == 0) ? q0.size() : q1.size();
    check($sformatf("r%0d_ack_expected", i), 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      e = (i == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("r%0d_err", i), 32'(err), 32'(e[32]));
      check($sformatf("r%0d_rdata", i), rdata, e[31:0]);
    end
  endtask

  always @(posedge Clk) begin
    #1;
    if (ack[0]) mon(0);
    if (ack[1]) mon(1);
  end

  // Issue one access and hold req until its ack; returns the DM bus as seen
  // in the cycle before the ack (the access's BUSY cycle).
  task automatic do_req(input int i, input logic [12:0] a, input logic [31:0] wd,
                        input logic we, input logic [1:0] sz, input logic sx,
                        output logic [10:0] sa, output logic [3:0] sbe,
                        output logic swe);
    logic got;
    sa = '0; sbe = '0; swe = 1'b0; got = 1'b0;
    @(negedge Clk);
    model(i, a, wd, we, sz, sx);
    if (i == 0) begin
      addr0 = a; wdata0 = wd; we0 = we; size0 = sz; sext0 = sx; rq0 = 1'b1;
    end else begin
      addr1 = a; wdata1 = wd; we1 = we; size1 = sz; sext1 = sx; rq1 = 1'b1;
    end
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge Clk);
      #1;
      if (ack[i]) got = 1'b1;
      else begin sa = dm_A; sbe = dm_BE; swe = dm_We; end
    end
    if (i == 0) rq0 = 1'b0; else rq1 = 1'b0;
    check($sformatf("r%0d_ack_within_budget", i), 32'(got), 32'd1);
  endtask

  task automatic rand_thread(input int i, input logic [12:0] base);
    logic [10:0] sa; logic [3:0] sbe; logic swe;
    logic [12:0] off;
    logic [1:0] sz;
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge Clk);
      sz  = 2'($urandom_range(0, 3));
      off = 13'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) off = off & ~13'((1 << sz) - 1);
      do_req(i, base + off, $urandom, 1'($urandom_range(0, 1)), sz,
             1'($urandom_range(0, 1)), sa, sbe, swe);
    end
  endtask

  logic [10:0] sa;
  logic [3:0]  sbe;
  logic        swe;
  int          c0, c1;

  initial begin
    Reset = 1'b1; rq0 = 1'b0; rq1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    we0 = 1'b0; we1 = 1'b0; size0 = 2'b00; size1 = 2'b00; sext0 = 1'b0; sext1 = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_dm_We", 32'(dm_We), 32'd0);
    check("reset_dm_BE", 32'(dm_BE), 32'd0);
`ifdef DM_ARB_STATS_EN
    check("reset_stall0", 32'(stall0), 32'd0);
    check("reset_stall1", 32'(stall1), 32'd0);
`endif

    // Both requesters in the first cycle after reset: 0 first, then 1.
    @(negedge Clk);
    Reset = 1'b0;
    addr0 = 13'h100; we0 = 1'b0; size0 = 2'b10; sext0 = 1'b0;
    addr1 = 13'h104; we1 = 1'b0; size1 = 2'b10; sext1 = 1'b0;
    model(0, 13'h100, 32'h0, 1'b0, 2'b10, 1'b0);
    model(1, 13'h104, 32'h0, 1'b0, 2'b10, 1'b0);
    rq0 = 1'b1; rq1 = 1'b1; c0 = 0; c1 = 0;
    for (int c = 1; c <= 12 && c1 == 0; c++) begin
      @(posedge Clk);
      #1;
      if (ack[0] && c0 == 0) begin c0 = c; rq0 = 1'b0; end
      if (ack[1] && c1 == 0) begin
        c1 = c; rq1 = 1'b0;
`ifdef DM_ARB_STATS_EN
        check("stall0_contended", 32'(stall0), 32'd1);
        check("stall1_contended", 32'(stall1), 32'd3);
`endif
      end
    end
    check("contend_ack0_cycle", 32'(c0), 32'd2);
    check("contend_ack1_cycle", 32'(c1), 32'd4);

    // Word store then sign-extended byte load of the top byte.
    do_req(0, 13'h010, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, sa, sbe, swe);
    check("st_word_BE", 32'(sbe), 32'hF);
    check("st_word_We", 32'(swe), 32'd1);
    check("st_word_A", 32'(sa), 32'h004);
    do_req(0, 13'h013, 32'h0, 1'b0, 2'b00, 1'b1, sa, sbe, swe);
    check("ld_byte_BE", 32'(sbe), 32'h8);

    // Upper-half store and zero-extended reload by requester 1.
    do_req(1, 13'h022, 32'h00001234, 1'b1, 2'b01, 1'b0, sa, sbe, swe);
    check("st_half_BE", 32'(sbe), 32'hC);
    check("st_half_A", 32'(sa), 32'h008);
    do_req(1, 13'h022, 32'h0, 1'b0, 2'b01, 1'b0, sa, sbe, swe);

    // Misaligned word store must not touch memory.
    do_req(0, 13'h005, 32'h12345678, 1'b1, 2'b10, 1'b0, sa, sbe, swe);
    check("misal_We", 32'(swe), 32'd0);
    check("misal_BE", 32'(sbe), 32'd0);
    do_req(0, 13'h004, 32'h0, 1'b0, 2'b10, 1'b0, sa, sbe, swe);

    // Reset in the BUSY cycle of a store aborts it.
    do_req(0, 13'h040, 32'hCAFEF00D, 1'b1, 2'b10, 1'b0, sa, sbe, swe);
    repeat (2) @(negedge Clk);
    addr0 = 13'h040; wdata0 = 32'h11111111; we0 = 1'b1; size0 = 2'b10; sext0 = 1'b0;
    rq0 = 1'b1;
    @(posedge Clk);
    #1;
    check("busy_We_before_reset", 32'(dm_We), 32'd1);
    Reset = 1'b1;
    #1;
    check("abort_We", 32'(dm_We), 32'd0);
    check("abort_BE", 32'(dm_BE), 32'd0);
    rq0 = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_ack", 32'(ack), 32'd0);
`ifdef DM_ARB_STATS_EN
    check("abort_stall0", 32'(stall0), 32'd0);
`endif
    do_req(0, 13'h040, 32'h0, 1'b0, 2'b10, 1'b0, sa, sbe, swe);

    // Randomised traffic from both requesters in disjoint regions.
    fork
      rand_thread(0, 13'h200);
      rand_thread(1, 13'h400);
    join

    repeat (5) @(posedge Clk);
    #2;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port (11-bit word address, byte-enable write, combinational read) between two requesters.
  - Requester 0: CPU MEM stage.
  - Requester 1: debug/loader port.
- Arbitrates round-robin, converts byte-addressed, sized accesses into word address plus BE, and checks alignment.
- Returns a registered, lane-extracted and extended load result with a one-cycle ack.
- Sits between the requesters and the DM macro; the DM itself is unchanged.

Parameters:
- AW, 13: byte-address width; the DM word address is AW-2 = 11 bits.
- CNT_W, 16: width of the stall counters (optional feature only).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  2  per-requester access request; held until the matching ack.
- addr0 / addr1  in  AW  byte address.
- wdata0 / wdata1  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- we0 / we1  in  1  1 = store, 0 = load.
- size0 / size1  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- sext0 / sext1  in  1  load sign-extend (1) or zero-extend (0).
- ack  out  2  one-cycle completion pulse per requester.
- err  out  1  valid with ack; misaligned or illegal size.
- rdata  out  32  load result, valid with ack; 0 for stores and errors.
- dm_A  out  11  word address to the DM.
- dm_WD  out  32  store data to the DM, unshifted (the DM lane-steers internally).
- dm_We  out  1  DM write enable.
- dm_BE  out  4  DM byte enables.
- dm_RD  in  32  DM combinational read data.

Behaviour:
- States: IDLE, BUSY.
- Reset (async): state = IDLE, ack = 0, err = 0, rdata = 0, last_gnt = 1, latched request cleared.
  - dm_We = 0 and dm_BE = 0 immediately.
  - A reset during BUSY aborts the access: no DM write, no ack.
- IDLE:
  - Eligible requesters: req[i]=1 && ack[i]=0. Requesters that are acking this cycle are ignored, so no double issue.
  - If no requester is eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the one not equal to last_gnt.
  - On grant: latch addr, wdata, we, size, sext and the winner index; update last_gnt; go to BUSY.
- BUSY (exactly one cycle):
  - dm_A = addr[AW-1:2]; dm_WD = wdata.
  - dm_BE:
    - Byte access: 0001 << addr[1:0].
    - Half access: 0011 (addr[1]=0) or 1100 (addr[1]=1).
    - Word access: 1111.
  - Error condition: size 11, or half with addr[0]=1, or word with addr[1:0]≠0.
  - dm_We = we && !error. On error, dm_BE = 0.
  - At the closing edge: ack[winner] <= 1, err <= error.
  - rdata on that edge:
    - Load without error: selected lane of dm_RD, sign- or zero-extended to 32 bits.
    - Otherwise: 0.
  - Return to IDLE.
- Outside BUSY: dm_We = 0, dm_BE = 0, dm_A and dm_WD hold the last latched values.
- ack is a single-cycle pulse. A request issued in cycle N is acked in cycle N+2, when it wins immediately.
- Throughput: one access per 2 cycles. The other requester may be granted in the cycle the first requester is acked.
- Store-then-load to the same address by the same requester returns the new data.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- Defined: adds outputs stall0 and stall1, each CNT_W bits.
  - Each counts cycles with req[i]=1, ack[i]=0, and requester i not granted that cycle.
  - Counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dm_arb_pkg holds:
  - Size encodings: SZ_B, SZ_H, SZ_W, SZ_BAD.
  - State enum: IDLE, BUSY.
  - Function for BE generation.
- Sub-module dm_lane_unit, purely combinational:
  - Inputs: size, addr[1:0], sext, dm_RD.
  - Outputs: BE, error, extended load data.
  - Instantiated once inside the arbiter.

Test Plan:
- Requester 0 stores word 0xDEADBEEF at byte 0x010, then loads a byte at 0x013 with sext=1 -> dm_BE=1111 on the store; load returns rdata=0xFFFFFFDE, ack[0] pulse, err=0.
- Requester 1 does a half store of 0x00001234 at 0x022, then a half load at 0x022 with sext=0 -> dm_BE=1100, dm_A=0x008; rdata=0x00001234.
- req=11 asserted together in the first cycle after reset -> requester 0 is granted first (last_gnt=1) and acked at cycle 2; requester 1 is acked at cycle 4; no double issue to requester 0.
- Word store at byte address 0x005 -> dm_We stays 0, err=1 with ack, memory unchanged (verified by a later aligned load).
- Reset asserted during BUSY of a store -> dm_We drops in the same cycle, no ack, target word unchanged.
- With DM_ARB_STATS_EN, hold req[1] high while requester 0 wins 3 contended rounds -> stall1 increments on each of requester 1's waiting cycles; both counters are 0 after reset.
